// File: rtl/gate_exerciser.sv
// Drives a 2-input gate through {a,b}=00,01,10,11, samples y after a settle time and checks it against EXP_TT.
// Optional macro GATE_EXERCISER_SYNC_EN: 2-flop synchroniser on dut_y and two extra settle edges per vector.
module gate_exerciser #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  EXP_TT        = 4'b1000,
    parameter int unsigned ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             dut_y,
    output logic             dut_a,
    output logic             dut_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

`ifdef GATE_EXERCISER_SYNC_EN
    localparam int unsigned SETTLE_LEN = SETTLE_CYCLES + 2;
`else
    localparam int unsigned SETTLE_LEN = SETTLE_CYCLES;
`endif
    localparam logic [8:0] SETTLE_LAST = 9'(SETTLE_LEN - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_idx;
    logic [1:0]       w_idx_next;
    logic [8:0]       r_cnt;
    logic [8:0]       w_cnt_next;
    logic [1:0]       r_ab;
    logic [1:0]       w_ab_next;
    logic             r_busy;
    logic             w_busy_next;
    logic             r_done;
    logic             w_done_next;
    logic             r_pass;
    logic             w_pass_next;
    logic [ERR_W-1:0] r_err;
    logic [ERR_W-1:0] w_err_next;
    logic [ERR_W-1:0] w_err_upd;
    logic [3:0]       r_fail;
    logic [3:0]       w_fail_next;
    logic [3:0]       w_fail_upd;
    logic             w_y;
    logic             w_mismatch;

`ifdef GATE_EXERCISER_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], dut_y};
        end
    end

    assign w_y = r_sync[1];
`else
    assign w_y = dut_y;
`endif

    // Case-inequality so an X/Z output from the gate is reported, not silently accepted.
    assign w_mismatch = (w_y !== EXP_TT[r_idx]);
    assign w_err_upd  = (w_mismatch && (r_err != '1)) ? r_err + ERR_W'(1) : r_err;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fail
            assign w_fail_upd[gi] = r_fail[gi] | (w_mismatch && (r_idx == 2'(gi)));
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_cnt_next   = r_cnt;
        w_ab_next    = r_ab;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;
        w_pass_next  = r_pass;
        w_err_next   = r_err;
        w_fail_next  = r_fail;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_SETTLE;
                    w_idx_next   = 2'd0;
                    w_cnt_next   = '0;
                    w_ab_next    = 2'b00;
                    w_busy_next  = 1'b1;
                    w_pass_next  = 1'b0;
                    w_err_next   = '0;
                    w_fail_next  = 4'b0000;
                end
            end
            ST_SETTLE, ST_SAMPLE: begin
                if (abort) begin
                    // Partial err_count/fail_vec are kept for post-mortem; the pending sample is dropped.
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                    w_ab_next    = 2'b00;
                    w_busy_next  = 1'b0;
                    w_pass_next  = 1'b0;
                end else if (r_state == ST_SETTLE) begin
                    if (r_cnt == SETTLE_LAST) begin
                        w_cnt_next   = '0;
                        w_state_next = ST_SAMPLE;
                    end else begin
                        w_cnt_next = r_cnt + 9'd1;
                    end
                end else begin
                    w_err_next  = w_err_upd;
                    w_fail_next = w_fail_upd;
                    if (r_idx == 2'd3) begin
                        w_state_next = ST_DONE;
                        w_busy_next  = 1'b0;
                        w_done_next  = 1'b1;
                        w_pass_next  = (w_err_upd == '0);
                    end else begin
                        w_idx_next   = r_idx + 2'd1;
                        w_ab_next    = r_idx + 2'd1;
                        w_state_next = ST_SETTLE;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
                w_ab_next    = 2'b00;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= 2'd0;
            r_cnt   <= '0;
            r_ab    <= 2'b00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_fail  <= 4'b0000;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_cnt   <= w_cnt_next;
            r_ab    <= w_ab_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_pass  <= w_pass_next;
            r_err   <= w_err_next;
            r_fail  <= w_fail_next;
        end
    end

    assign dut_a     = r_ab[1];
    assign dut_b     = r_ab[0];
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_vec  = r_fail;

endmodule

// File: tb/tb_gate_exerciser.sv
// Scoreboard bench for gate_exerciser: stimulus pushes expected run results, per-DUT monitors pop them on done.
// Two instances: AND checker (SETTLE_CYCLES=2) and OR checker (SETTLE_CYCLES=1, ERR_W=1).
module tb_gate_exerciser;

`ifdef GATE_EXERCISER_SYNC_EN
    localparam int P0 = 2 + 3;
    localparam int P1 = 1 + 3;
`else
    localparam int P0 = 2 + 1;
    localparam int P1 = 1 + 1;
`endif
    localparam int L0 = 4 * P0;
    localparam int L1 = 4 * P1;

    typedef struct {
        int         done_edge;
        logic       pass;
        int         err;
        logic [3:0] fail;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
    logic       a0, b0, busy0, done0, pass0, a1, b1, busy1, done1, pass1;
    logic       y0, y1;
    logic [3:0] err0;
    logic [0:0] err1;
    logic [3:0] fail0, fail1;
    int         mode0 = 0, mode1 = 3;
    int         cyc = 0;
    int         n_checks = 0, n_fail = 0;
    exp_t       q0[$], q1[$];

    // 0 AND, 1 stuck-at-0, 2 stuck-at-1, 3 OR, 4 NOR
    function automatic logic model(int m, logic a, logic b);
        case (m)
            0: return a & b;
            1: return 1'b0;
            2: return 1'b1;
            3: return a | b;
            default: return ~(a | b);
        endcase
    endfunction

    assign y0 = model(mode0, a0, b0);
    assign y1 = model(mode1, a1, b1);

    gate_exerciser #(.SETTLE_CYCLES(2), .EXP_TT(4'b1000), .ERR_W(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .dut_y(y0),
        .dut_a(a0), .dut_b(b0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_vec(fail0)
    );

    gate_exerciser #(.SETTLE_CYCLES(1), .EXP_TT(4'b1110), .ERR_W(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .dut_y(y1),
        .dut_a(a1), .dut_b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fail1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done0) begin
            if (q0.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut0_unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                e = q0.pop_front();
                $display("dut0 run done: cycle=%0d pass=%0b err=%0d fail_vec=%b", cyc, pass0, err0, fail0);
                chk("dut0_done_edge", cyc, e.done_edge);
                chk("dut0_pass", 32'(pass0), 32'(e.pass));
                chk("dut0_err", 32'(err0), e.err);
                chk("dut0_fail_vec", 32'(fail0), 32'(e.fail));
                chk("dut0_busy_at_done", 32'(busy0), 0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done1) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut1_unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                e = q1.pop_front();
                $display("dut1 run done: cycle=%0d pass=%0b err=%0d fail_vec=%b", cyc, pass1, err1, fail1);
                chk("dut1_done_edge", cyc, e.done_edge);
                chk("dut1_pass", 32'(pass1), 32'(e.pass));
                chk("dut1_err", 32'(err1), e.err);
                chk("dut1_fail_vec", 32'(fail1), 32'(e.fail));
            end
        end
    end

    task automatic run0(int mode, logic ep, int ee, logic [3:0] ef, logic with_abort);
        exp_t e;
        @(negedge clk);
        mode0 = mode; start0 = 1'b1; abort0 = with_abort;
        e.done_edge = cyc + 1 + L0; e.pass = ep; e.err = ee; e.fail = ef;
        q0.push_back(e);
        @(negedge clk);
        start0 = 1'b0; abort0 = 1'b0;
        chk("dut0_busy_after_start", 32'(busy0), 1);
        chk("dut0_err_cleared", 32'(err0), 0);
        chk("dut0_fail_cleared", 32'(fail0), 0);
        repeat (L0 + 2) @(negedge clk);
    endtask

    task automatic run1(int mode, logic ep, int ee, logic [3:0] ef);
        exp_t e;
        @(negedge clk);
        mode1 = mode; start1 = 1'b1;
        e.done_edge = cyc + 1 + L1; e.pass = ep; e.err = ee; e.fail = ef;
        q1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
        repeat (L1 + 2) @(negedge clk);
    endtask

    initial begin
        int   s;
        exp_t e;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_dut_a", 32'(a0), 0);
        chk("rst_dut_b", 32'(b0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_pass", 32'(pass0), 0);
        chk("rst_err", 32'(err0), 0);
        chk("rst_fail_vec", 32'(fail0), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // OR checker: correct OR passes; NOR mismatches every vector, 1-bit counter saturates
        run1(3, 1'b1, 0, 4'b0000);
        run1(4, 1'b0, 1, 4'b1111);

        // Correct AND, watching each vector being presented
        @(negedge clk);
        mode0 = 0; start0 = 1'b1;
        s = cyc + 1;
        e.done_edge = s + L0; e.pass = 1'b1; e.err = 0; e.fail = 4'b0000;
        q0.push_back(e);
        @(negedge clk);
        start0 = 1'b0;
        for (int v = 0; v < 4; v++) begin
            while (cyc < s + v * P0 + 1) @(negedge clk);
            chk($sformatf("vec%0d_ab", v), 32'({a0, b0}), v);
            chk($sformatf("vec%0d_busy", v), 32'(busy0), 1);
        end
        repeat (L0) @(negedge clk);
        chk("hold_pass_after_done", 32'(pass0), 1);
        chk("ab_idle_after_done", 32'({a0, b0}), 0);

        // Stuck-at-0 (start and abort together in IDLE: start wins), stuck-at-1
        run0(1, 1'b0, 1, 4'b1000, 1'b1);
        run0(2, 1'b0, 3, 4'b0111, 1'b0);

        // Abort during vector 2 settle with stuck-at-1: vectors 0,1 already counted
        @(negedge clk);
        mode0 = 2; start0 = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        start0 = 1'b0;
        while (cyc < s + 2 * P0 + 1) @(negedge clk);
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        $display("dut0 abort: cycle=%0d busy=%0b err=%0d fail_vec=%b", cyc, busy0, err0, fail0);
        chk("abort_busy", 32'(busy0), 0);
        chk("abort_pass", 32'(pass0), 0);
        chk("abort_ab", 32'({a0, b0}), 0);
        chk("abort_err_kept", 32'(err0), 2);
        chk("abort_fail_kept", 32'(fail0), 32'(4'b0011));
        repeat (L0) @(negedge clk);
        run0(0, 1'b1, 0, 4'b0000, 1'b0);

        // start held high: one run, then a new one two edges after the first DONE edge
        @(negedge clk);
        mode0 = 0; start0 = 1'b1;
        s = cyc + 1;
        e.done_edge = s + L0; e.pass = 1'b1; e.err = 0; e.fail = 4'b0000;
        q0.push_back(e);
        e.done_edge = s + 2 * L0 + 2;
        q0.push_back(e);
        while (cyc < s + L0 + 2) @(negedge clk);
        start0 = 1'b0;
        chk("restart_busy", 32'(busy0), 1);
        repeat (L0 + 2) @(negedge clk);

        // Asynchronous reset during vector 1 (b=1, err=1 from stuck-at-1 on vector 0)
        @(negedge clk);
        mode0 = 2; start0 = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        start0 = 1'b0;
        while (cyc < s + P0 + 1) @(negedge clk);
        chk("pre_rst_dut_b", 32'(b0), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_rst_busy", 32'(busy0), 0);
        chk("midrun_rst_dut_b", 32'(b0), 0);
        chk("midrun_rst_err", 32'(err0), 0);
        chk("midrun_rst_fail_vec", 32'(fail0), 0);
        chk("midrun_rst_done", 32'(done0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (L0 + 2) @(negedge clk);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
